vga_fill_engine: RTL and testbench

VGA_FILL_ENGINE -- requirements
Module: vga_fill_engine

---
 rtl/vga_fill_engine.sv | 142 ++++++++++++++
 tb/tb_vga_fill_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fill_engine.sv
// rtl/vga_fill_engine.sv - register-programmed rectangle fill engine for a framebuffer
module vga_fill_engine #(
  parameter int FB_XW = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid,
  input  logic [3:0]           addr,
  input  logic [31:0]          wdata,
  input  logic                 wstrb,
  output logic [31:0]          rdata,
  output logic                 fb_we,
  output logic [2*FB_XW-1:0]   fb_addr,
  output logic [7:0]           fb_data,
  output logic                 busy
);

  localparam int CW = 2*FB_XW + 1;
  localparam logic [FB_XW:0] ONE = 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, state_nxt;
  logic [FB_XW-1:0]   x0, y0;
  logic [FB_XW:0]     w, h;
  logic [7:0]         color;
  logic [FB_XW:0]     col, row;
  logic [CW-1:0]      count;
  logic               done;
  logic [FB_XW-1:0]   cur_x, cur_y;

  logic wr_en, ctrl_wr, start_req, abort_req, last_px, size_zero;

  assign wr_en     = valid & wstrb;
  assign ctrl_wr   = wr_en && (addr == 4'd5);
  // abort has priority over start when both bits are set in one write
  assign start_req = ctrl_wr & wdata[0] & ~wdata[1];
  assign abort_req = ctrl_wr & wdata[1];
  assign size_zero = (w == '0) || (h == '0);
  assign last_px   = (col == w - ONE) && (row == h - ONE);

  // pixel coordinates wrap modulo the framebuffer size, no clipping
  assign cur_x   = x0 + col[FB_XW-1:0];
  assign cur_y   = y0 + row[FB_XW-1:0];
  assign fb_addr = {cur_y, cur_x};
  assign fb_data = color;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state and fill outputs
  always_comb begin
    state_nxt = state;
    fb_we     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && !size_zero) state_nxt = FILL;
      end
      FILL: begin
        fb_we = 1'b1;
        busy  = 1'b1;
        if (abort_req || last_px) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // configuration registers; frozen while a fill runs so they double as the latched copy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0    <= '0;
      y0    <= '0;
      w     <= '0;
      h     <= '0;
      color <= '0;
    end else if (wr_en && !busy) begin
      case (addr)
        4'd0: x0    <= wdata[FB_XW-1:0];
        4'd1: y0    <= wdata[FB_XW-1:0];
        4'd2: w     <= wdata[FB_XW:0];
        4'd3: h     <= wdata[FB_XW:0];
        4'd4: color <= wdata[7:0];
        default: ;
      endcase
    end
  end

  // row-major walk offsets, parked at zero whenever no fill continues
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (state == FILL && state_nxt == FILL) begin
      if (col == w - ONE) begin
        col <= '0;
        row <= row + ONE;
      end else begin
        col <= col + ONE;
      end
    end else begin
      col <= '0;
      row <= '0;
    end
  end

  // pixel counter and completion flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      done  <= 1'b0;
    end else if (start_req && state == IDLE) begin
      count <= '0;
      done  <= size_zero;
    end else if (fb_we) begin
      count <= count + 1'b1;
      if (last_px && !abort_req) done <= 1'b1;
    end
  end

  // registered read mux, updated every cycle from addr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else begin
      case (addr)
        4'd0:    rdata <= 32'(x0);
        4'd1:    rdata <= 32'(y0);
        4'd2:    rdata <= 32'(w);
        4'd3:    rdata <= 32'(h);
        4'd4:    rdata <= 32'(color);
        4'd5:    rdata <= {30'd0, done, busy};
        4'd6:    rdata <= 32'(count);
        default: rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
// tb/tb_vga_fill_engine.sv - self-checking bench for vga_fill_engine
module tb_vga_fill_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        wstrb;
  logic [31:0] rdata;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  logic [15:0] cap_addr[$];
  logic [7:0]  cap_data[$];

  vga_fill_engine #(.FB_XW(8)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // record every framebuffer write and every busy cycle
  always @(negedge clk) begin
    if (fb_we) begin
      cap_addr.push_back(fb_addr);
      cap_data.push_back(fb_data);
    end
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    addr = a[3:0]; wdata = d; wstrb = 1'b1; valid = 1'b1;
    step();
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    addr = a[3:0]; wstrb = 1'b0; valid = 1'b1;
    step();
    d = rdata;
    valid = 1'b0;
  endtask

  // reference: pixel i of a W-wide rectangle sits at row i/W, column i%W, both wrapping mod 256
  function automatic logic [15:0] model_addr(input int x0, input int y0, input int w, input int i);
    int px, py;
    px = (x0 + i % w) % 256;
    py = (y0 + i / w) % 256;
    return 16'(py * 256 + px);
  endfunction

  task automatic run_fill(input string tag, input int x0, input int y0, input int w,
                          input int h, input int c, input bit mid);
    logic [31:0] r;
    int n, bad;
    wr(0, x0); wr(1, y0); wr(2, w); wr(3, h); wr(4, c);
    cap_addr.delete(); cap_data.delete(); busy_cnt = 0;
    wr(5, 1);
    check({tag, "_first_we"}, 32'(fb_we), 1);
    if (mid) begin
      wr(4, c ^ 8'hFF);
      wr(0, x0 + 7);
      wr(3, h + 1);
      wr(5, 1);
    end
    n = 0;
    while (busy && n < 5000) begin step(); n++; end
    if (busy) check({tag, "_timeout"}, 1, 0);
    check({tag, "_npix"}, cap_addr.size(), w * h);
    check({tag, "_busy_cyc"}, busy_cnt, w * h);
    bad = 0;
    foreach (cap_addr[i]) begin
      if (cap_addr[i] !== model_addr(x0, y0, w, i) || cap_data[i] !== 8'(c)) bad++;
    end
    check({tag, "_seq_errs"}, bad, 0);
    rd(6, r); check({tag, "_count"}, r, w * h);
    rd(5, r); check({tag, "_ctrl"}, r, 32'h2);
    if (mid) begin
      rd(0, r); check({tag, "_x0_kept"}, r, x0);
      rd(4, r); check({tag, "_color_kept"}, r, c);
    end
  endtask

  initial begin
    logic [31:0] r;
    int n, bad, col;
    resetn = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wstrb = 1'b0;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_rdata", rdata, 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    resetn = 1'b1;
    step();
    rd(5, r); check("rst_ctrl", r, 0);
    rd(6, r); check("rst_count", r, 0);

    // basic rectangle
    run_fill("basic", 10, 20, 3, 2, 8'hE0, 1'b0);
    check("basic_a0", 32'(cap_addr[0]), 32'h140A);
    check("basic_a3", 32'(cap_addr[3]), 32'h150A);
    check("basic_a5", 32'(cap_addr[5]), 32'h150C);

    // wrap-around in both axes
    run_fill("wrap", 254, 255, 4, 2, 8'h3C, 1'b0);
    check("wrap_a2", 32'(cap_addr[2]), 32'hFF00);
    check("wrap_a4", 32'(cap_addr[4]), 32'h00FE);
    check("wrap_a7", 32'(cap_addr[7]), 32'h0001);

    // randomized rectangles
    for (int t = 0; t < 8; t++) begin
      run_fill("rand", $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(1, 16), $urandom_range(1, 12), $urandom_range(0, 255), 1'b0);
    end

    // writes and restart attempts during a fill
    run_fill("midwr", 250, 100, 5, 3, 8'hA5, 1'b1);

    // zero-size start clears COUNT and reports done without writing
    wr(2, 0); wr(3, 5);
    cap_addr.delete(); cap_data.delete(); busy_cnt = 0;
    wr(5, 1);
    step(); step();
    check("zero_npix", cap_addr.size(), 0);
    check("zero_busy", busy_cnt, 0);
    rd(5, r); check("zero_ctrl", r, 32'h2);
    rd(6, r); check("zero_count", r, 0);

    // start and abort together while idle does nothing
    wr(2, 4); wr(3, 4);
    wr(5, 3);
    check("startabort_busy", 32'(busy), 0);
    check("startabort_we", 32'(fb_we), 0);

    // abort after 100 pixels of a full-screen fill
    wr(0, 3); wr(1, 7); wr(2, 256); wr(3, 256); wr(4, 8'h5A);
    cap_addr.delete(); cap_data.delete(); busy_cnt = 0;
    wr(5, 1);
    wr(4, 8'h11);
    n = 0;
    while (cap_addr.size() < 100 && n < 1000) begin step(); n++; end
    check("abort_reach100", cap_addr.size(), 100);
    wr(5, 2);
    check("abort_we_low", 32'(fb_we), 0);
    check("abort_busy_low", 32'(busy), 0);
    check("abort_npix", cap_addr.size(), 100);
    rd(6, r); check("abort_count", r, 100);
    rd(5, r); check("abort_ctrl", r, 0);
    bad = 0;
    foreach (cap_addr[i]) begin
      if (cap_addr[i] !== model_addr(3, 7, 256, i) || cap_data[i] !== 8'h5A) bad++;
    end
    check("abort_seq_errs", bad, 0);

    // asynchronous reset in the middle of a fill
    wr(4, 8'h77);
    wr(5, 1);
    for (int i = 0; i < 20; i++) step();
    #2 resetn = 1'b0;
    #1;
    check("arst_we", 32'(fb_we), 0);
    check("arst_busy", 32'(busy), 0);
    step();
    resetn = 1'b1;
    cap_addr.delete(); cap_data.delete(); busy_cnt = 0;
    for (int i = 0; i < 5; i++) step();
    check("arst_no_we", cap_addr.size(), 0);
    check("arst_no_busy", busy_cnt, 0);
    for (int a = 0; a < 7; a++) begin
      rd(a, r);
      check($sformatf("arst_reg%0d", a), r, 0);
    end

    // unmapped index reads zero
    wr(4, 8'hC3);
    rd(9, r); check("unmapped", r, 0);
    rd(4, r); check("color_rb", r, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
